button_press_handshake: RTL and testbench

Converts a raw, bouncing push-button pin into single "press" events on a valid/ready handshake. Used in the top level to trigger one keyboard command transfer per press, e.g. sending the PS/2 reset command 0xFF.

---
 rtl/button_press_handshake_pkg.sv | 14 +
 rtl/button_debouncer.sv | 57 +++++
 rtl/button_press_handshake.sv | 82 ++++++++
 tb/tb_button_press_handshake.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/button_press_handshake_pkg.sv
// Shared level constants and counter-width helper for the button press path.
package button_press_handshake_pkg;

  localparam logic YES  = 1'b1;
  localparam logic NO   = 1'b0;
  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus persistence-count debouncer producing a clean
// pressed level (1 = held) and a one-cycle flag on the edge it goes 0->1.
module button_debouncer
  import button_press_handshake_pkg::*;
#(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic pressed,
  output logic rise,
  output logic released
);

  localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic          raw;
  logic          s1;
  logic          s2;
  logic [1:0]    fill;
  logic [CW-1:0] cnt;

  assign raw = button ^ (ACTIVE_LOW != 0);

  // rise is true on the edge where pressed is about to take the value 1.
  assign rise = (s2 != pressed) && (cnt == TERM) && (s2 == HIGH);

  // fill marks that s2 holds a real pin sample rather than its reset value,
  // so the parent can tell a genuinely released button after reset.
  assign released = fill[1] && (s2 == LOW);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1      <= LOW;
      s2      <= LOW;
      fill    <= 2'b00;
      cnt     <= '0;
      pressed <= LOW;
    end else begin
      s1   <= raw;
      s2   <= s1;
      fill <= {fill[0], 1'b1};
      if (s2 == pressed) begin
        cnt <= '0;
      end else if (cnt == TERM) begin
        pressed <= s2;
        cnt     <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/button_press_handshake.sv
// Turns a bouncing push-button into single press events on a one-deep
// valid/ready output, with optional auto-repeat while the button is held.
module button_press_handshake
  import button_press_handshake_pkg::*;
#(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  input  logic ready,
  output logic valid,
  output logic pressed
);

  logic rise;
  logic released;
  logic armed;
  logic rep_fire;
  logic event_now;
  logic xfer;

  button_debouncer #(
    .ACTIVE_LOW      (ACTIVE_LOW),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk      (clk),
    .reset    (reset),
    .button   (button),
    .pressed  (pressed),
    .rise     (rise),
    .released (released)
  );

  generate
    if (REPEAT_CYCLES > 0) begin : g_repeat
      localparam int            RW    = cnt_width(REPEAT_CYCLES);
      localparam logic [RW-1:0] RTERM = RW'(REPEAT_CYCLES - 1);
      logic [RW-1:0] rep_cnt;

      always_ff @(posedge clk) begin
        if (reset) begin
          rep_cnt <= '0;
        end else if (rise || !pressed || (rep_cnt == RTERM)) begin
          rep_cnt <= '0;
        end else begin
          rep_cnt <= rep_cnt + RW'(1);
        end
      end

      assign rep_fire = pressed && (rep_cnt == RTERM);
    end else begin : g_no_repeat
      assign rep_fire = NO;
    end
  endgenerate

  // Events are suppressed until the synchronised pin has been seen released
  // after reset, so a button held through reset never fires on exit.
  assign event_now = armed && (rise || rep_fire);

  // Handshake: a transfer happens on every edge with valid && ready. valid
  // then clears unless a new event lands on that same edge; an event that
  // arrives while valid is already high without a transfer is coalesced.
  assign xfer = valid && ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= NO;
      armed <= NO;
    end else begin
      if (released) armed <= YES;
      if (event_now) begin
        valid <= YES;
      end else if (xfer) begin
        valid <= NO;
      end
    end
  end

endmodule

// File: tb/tb_button_press_handshake.sv
// Bench for button_press_handshake: an active-low instance without repeat and
// an active-high instance with repeat, both driven by the same logical button.
module tb_button_press_handshake;

  logic clk;
  logic reset;
  logic button;
  logic button_n;
  logic ready;
  logic valid_a, pressed_a;
  logic valid_r, pressed_r;

  assign button_n = ~button;

  button_press_handshake #(
    .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(0)
  ) dut_a (
    .clk(clk), .reset(reset), .button(button), .ready(ready),
    .valid(valid_a), .pressed(pressed_a)
  );

  button_press_handshake #(
    .ACTIVE_LOW(0), .DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(10)
  ) dut_r (
    .clk(clk), .reset(reset), .button(button_n), .ready(ready),
    .valid(valid_r), .pressed(pressed_r)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 0;
  int xa       = 0;
  int xr       = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // ---------------- reference model ----------------
  // Pressed level flips once the two-edge-delayed pin sample has disagreed
  // with it for DEBOUNCE consecutive edges; repeat events fire every REPEAT
  // held edges after the press; one event slot, new events coalesce.
  int dc[2] = '{4, 4};
  int rp[2] = '{0, 10};
  bit m_valid[2], m_pressed[2], m_armed[2];
  int m_run[2], m_since[2];
  bit hist[$];

  always @(posedge clk) begin
    bit s2p, ok, pp, rs, fire, ev;
    if (reset) begin
      hist.delete();
      for (int i = 0; i < 2; i++) begin
        m_valid[i] = 0; m_pressed[i] = 0; m_armed[i] = 0;
        m_run[i] = 0; m_since[i] = 0;
      end
    end else begin
      ok  = (hist.size() == 2);
      s2p = ok ? hist[0] : 1'b0;
      for (int i = 0; i < 2; i++) begin
        pp = m_pressed[i]; rs = 0; fire = 0;
        if (s2p != pp) begin
          m_run[i]++;
          if (m_run[i] == dc[i]) begin
            m_pressed[i] = s2p; m_run[i] = 0; rs = s2p;
          end
        end else m_run[i] = 0;
        if (rp[i] > 0) begin
          if (!pp || rs) m_since[i] = 0;
          else begin
            m_since[i]++;
            fire = (m_since[i] % rp[i] == 0);
          end
        end
        ev = m_armed[i] && (rs || fire);
        if (ok && !s2p) m_armed[i] = 1;
        if (ev) m_valid[i] = 1;
        else if (m_valid[i] && ready) m_valid[i] = 0;
      end
      hist.push_back(!button);
      if (hist.size() > 2) void'(hist.pop_front());
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_valid_a", valid_a, m_valid[0]);
      check("model_pressed_a", pressed_a, m_pressed[0]);
      check("model_valid_r", valid_r, m_valid[1]);
      check("model_pressed_r", pressed_r, m_pressed[1]);
    end
    if (valid_a && ready) xa++;
    if (valid_r && ready) xr++;
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    int   cycles;
    logic btn;
    logic rdy;
    logic exp_valid;
    logic exp_pressed;
  } vec_t;

  vec_t tbl[8];

  initial begin
    bit found;
    tbl[0] = '{20, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{5,  1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1,  1'b0, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{50, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{10, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{3,  1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1,  1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{5,  1'b1, 1'b0, 1'b0, 1'b0};

    reset = 1; button = 1; ready = 0;
    step(2);
    chk_en = 1;
    check("reset_valid_a", valid_a, 0);
    check("reset_pressed_a", pressed_a, 0);
    check("reset_valid_r", valid_r, 0);
    check("reset_pressed_r", pressed_r, 0);
    reset = 0;

    for (int i = 0; i < 8; i++) begin
      button = tbl[i].btn; ready = tbl[i].rdy;
      step(tbl[i].cycles);
      check($sformatf("vec%0d_valid_a", i), valid_a, tbl[i].exp_valid);
      check($sformatf("vec%0d_pressed_a", i), pressed_a, tbl[i].exp_pressed);
      check($sformatf("vec%0d_valid_r", i), valid_r, tbl[i].exp_valid);
      check($sformatf("vec%0d_pressed_r", i), pressed_r, tbl[i].exp_pressed);
    end

    // Bounce then settle pressed: one event only.
    ready = 1; xa = 0;
    for (int j = 0; j < 10; j++) begin
      button = (j % 2 == 1);
      step(2);
    end
    button = 0;
    step(20);
    check("bounce_events", xa, 1);

    // One-cycle glitch while held, then a clean release: no events.
    xa = 0;
    button = 1; step(1);
    button = 0; step(20);
    check("glitch_held", pressed_a, 1);
    button = 1; step(20);
    check("release_level", pressed_a, 0);
    check("glitch_release_events", xa, 0);

    // Two presses with ready low coalesce into one pending event.
    ready = 0;
    for (int k = 0; k < 2; k++) begin
      button = 0; step(10);
      button = 1; step(10);
    end
    check("coalesce_pending", valid_a, 1);
    xa = 0; ready = 1;
    step(1);
    check("coalesce_cleared", valid_a, 0);
    check("coalesce_transfers", xa, 1);
    ready = 0;

    // Auto-repeat while held.
    ready = 1; button = 0; found = 0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      if (valid_r) begin
        found = 1;
        break;
      end
    end
    check("repeat_start", found, 1);
    xr = 0;
    step(40);
    check("repeat_transfers", xr, 4);

    // Reset mid-hold drops the event and stays quiet while still held.
    reset = 1; step(1);
    check("midreset_valid_r", valid_r, 0);
    check("midreset_pressed_r", pressed_r, 0);
    check("midreset_valid_a", valid_a, 0);
    reset = 0; ready = 0;
    step(30);
    check("held_after_reset_valid_r", valid_r, 0);
    check("held_after_reset_valid_a", valid_a, 0);
    check("held_after_reset_pressed_r", pressed_r, 1);
    button = 1; step(20);
    button = 0; step(10);
    check("repress_valid_r", valid_r, 1);
    check("repress_valid_a", valid_a, 1);

    // Randomised segments checked against the model every cycle.
    for (int seg = 0; seg < 200; seg++) begin
      int dur;
      button = 1'($urandom_range(0, 1));
      dur = $urandom_range(1, 12);
      for (int c = 0; c < dur; c++) begin
        ready = ($urandom_range(0, 3) != 0);
        reset = ($urandom_range(0, 199) == 0);
        step(1);
      end
    end
    reset = 0; button = 1; ready = 1;
    step(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

endmodule
